// File: rtl/button_pkg.sv
// Shared types and timing constants for the push-button conditioning slice.
package button_pkg;

  localparam int DEBOUNCE_10MS_100MHZ = 1000000;
  localparam int LONG_1S_100MHZ       = 100000000;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } btn_state_e;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: resync chain, debounce FSM, long-press timer and a registered output stage.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int LONG_CYCLES     = LONG_1S_100MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int DW = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   synced;
  btn_state_e             state;
  logic [DW-1:0]          dcnt;
  logic                   rise_p0;
  logic                   fall_p0;
  logic                   lp_p0;

  // Stage p0: resynchronisation and debounce decision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
    end
  end

  assign synced = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_LOW;
      dcnt    <= '0;
      rise_p0 <= 1'b0;
      fall_p0 <= 1'b0;
    end else begin
      rise_p0 <= 1'b0;
      fall_p0 <= 1'b0;
      if (synced == (state == ST_HIGH)) begin
        dcnt <= '0;
      end else if (dcnt == DMAX) begin
        dcnt    <= '0;
        state   <= synced ? ST_HIGH : ST_LOW;
        rise_p0 <= synced;
        fall_p0 <= ~synced;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  if (LONG_CYCLES > 0) begin : g_long
    localparam int HW = clog2_min1(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES);
    logic [HW-1:0] hcnt;

    // Saturates at HMAX so the pulse can only fire once per press.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hcnt  <= '0;
        lp_p0 <= 1'b0;
      end else begin
        lp_p0 <= 1'b0;
        if (state == ST_LOW) begin
          hcnt <= '0;
        end else if (hcnt != HMAX) begin
          hcnt  <= hcnt + 1'b1;
          lp_p0 <= (hcnt == HMAX - 1'b1);
        end
      end
    end
  end else begin : g_no_long
    assign lp_p0 = 1'b0;
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      level      <= (state == ST_HIGH);
      rise       <= rise_p0;
      fall       <= fall_p0;
      long_press <= lp_p0;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: optional input inversion feeding independent channels.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CHANNELS        = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int LONG_CYCLES     = LONG_1S_100MHZ,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  logic [CHANNELS-1:0] din;

  // Inversion happens ahead of the first sync flop so every channel sees 1 = pressed.
  assign din = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din[i]),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: active-high and active-low instances share clock and reset.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn;
  logic [1:0] level, rise, fall, lp;
  logic [1:0] btn_al;
  logic [1:0] level_al, rise_al, fall_al, lp_al;

  int errors = 0;
  int checks = 0;

  button_conditioner #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn),
    .level(level), .rise(rise), .fall(fall), .long_press(lp)
  );

  button_conditioner #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1)
  ) u_dut_al (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_al),
    .level(level_al), .rise(rise_al), .fall(fall_al), .long_press(lp_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] el, input logic [1:0] er,
                         input logic [1:0] ef, input logic [1:0] ep);
    chk({tag, ".level"}, level, el);
    chk({tag, ".rise"},  rise,  er);
    chk({tag, ".fall"},  fall,  ef);
    chk({tag, ".long"},  lp,    ep);
  endtask

  task automatic chk_al(input string tag, input logic [1:0] el, input logic [1:0] er);
    chk({tag, ".al_level"}, level_al, el);
    chk({tag, ".al_rise"},  rise_al,  er);
    chk({tag, ".al_fall"},  fall_al,  2'b00);
    chk({tag, ".al_long"},  lp_al,    2'b00);
  endtask

  initial begin
    logic [5:0] bounce;
    bounce = 6'b101101;   // edge0..edge5 = 1,0,1,1,0,1 (LSB first)
    rst_n  = 1'b0;
    btn    = 2'b11;
    btn_al = 2'b11;

    // Reset held with inputs active
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    btn   = 2'b00;
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk_all("idle", 2'b00, 2'b00, 2'b00, 2'b00);
      chk_al("al_idle", 2'b00, 2'b00);
    end

    // Clean press held through long press, no repeat
    btn = 2'b01;
    for (int e = 0; e <= 30; e++) begin
      tick();
      chk_all($sformatf("press1_e%0d", e), (e >= 6) ? 2'b01 : 2'b00,
              (e == 6) ? 2'b01 : 2'b00, 2'b00, (e == 16) ? 2'b01 : 2'b00);
    end
    btn = 2'b00;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk_all($sformatf("release1_e%0d", e), (e < 6) ? 2'b01 : 2'b00,
              2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00);
    end

    // Second press fires long_press again
    btn = 2'b01;
    for (int e = 0; e <= 20; e++) begin
      tick();
      chk_all($sformatf("press2_e%0d", e), (e >= 6) ? 2'b01 : 2'b00,
              (e == 6) ? 2'b01 : 2'b00, 2'b00, (e == 16) ? 2'b01 : 2'b00);
    end
    btn = 2'b00;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk_all($sformatf("release2_e%0d", e), (e < 6) ? 2'b01 : 2'b00,
              2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00);
    end

    // Three-cycle glitch is rejected
    for (int e = 0; e <= 11; e++) begin
      btn = (e < 3) ? 2'b01 : 2'b00;
      tick();
      chk_all($sformatf("glitch_e%0d", e), 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Bounce 1,0,1,1,0,1 then steady: single rise 6 cycles after the last 0->1 (edge 5)
    for (int e = 0; e <= 12; e++) begin
      btn = {1'b0, (e < 6) ? bounce[e] : 1'b1};
      tick();
      chk_all($sformatf("bounce_e%0d", e), (e >= 11) ? 2'b01 : 2'b00,
              (e == 11) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end
    btn = 2'b00;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk_all($sformatf("release3_e%0d", e), (e < 6) ? 2'b01 : 2'b00,
              2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00);
    end

    // Both channels together
    btn = 2'b11;
    for (int e = 0; e <= 7; e++) begin
      tick();
      chk_all($sformatf("simul_e%0d", e), (e >= 6) ? 2'b11 : 2'b00,
              (e == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00);
    end
    btn = 2'b00;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk_all($sformatf("simul_rel_e%0d", e), (e < 6) ? 2'b11 : 2'b00,
              2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00);
    end

    // Reset while dcnt=2, input stays held
    btn = 2'b01;
    for (int e = 0; e <= 3; e++) begin
      tick();
      chk_all($sformatf("premid_e%0d", e), 2'b00, 2'b00, 2'b00, 2'b00);
    end
    rst_n = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk_all($sformatf("midrst_e%0d", e), 2'b00, 2'b00, 2'b00, 2'b00);
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      chk_all($sformatf("postrst_e%0d", e), (e >= 6) ? 2'b01 : 2'b00,
              (e == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end
    btn = 2'b00;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk_all($sformatf("postrst_rel_e%0d", e), (e < 6) ? 2'b01 : 2'b00,
              2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00);
    end

    // Active-low instance: idle high gave nothing, driving bit0 low is a press
    chk_al("al_before", 2'b00, 2'b00);
    btn_al = 2'b10;
    for (int e = 0; e <= 7; e++) begin
      tick();
      chk_al($sformatf("al_press_e%0d", e), (e >= 6) ? 2'b01 : 2'b00,
             (e == 6) ? 2'b01 : 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel successor to the single-button edge detector for the Atlys push-buttons and switches.
- Per channel:
  - resynchronises the asynchronous input through a parametrised flop chain;
  - debounces it with a stability counter;
  - publishes a clean level, one-cycle rise/fall pulses, and a one-shot long-press pulse.
- Sits between board pins and the main control FSM, replacing per-button edge detectors.

Parameters:
- CHANNELS, 6, number of independent inputs.
- SYNC_STAGES, 2, resync flop depth, legal range 2..4.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (10 ms at 100 MHz), must be >= 1.
- LONG_CYCLES, 100000000, cycles the clean level must stay 1 before long_press fires (1 s); 0 disables the feature.
- ACTIVE_LOW, 0, when 1 every btn_in bit is inverted before synchronisation.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- btn_in  in  CHANNELS  raw asynchronous inputs.
- level  out  CHANNELS  debounced level, 1 = pressed.
- rise  out  CHANNELS  one-cycle pulse on accepted 0->1.
- fall  out  CHANNELS  one-cycle pulse on accepted 1->0.
- long_press  out  CHANNELS  one-cycle pulse, at most once per press.

Behaviour:
- Reset (rst_n=0 at a clk edge): sync chain, counters, level, rise, fall and long_press all go to 0. The chain resets to the inactive value (post-inversion 0).
- Inversion: ACTIVE_LOW inversion is applied before the first sync flop. synced = last stage of the chain.
- Per-channel FSM, two states, LOW (level=0) and HIGH (level=1), plus debounce counter dcnt, width clog2(DEBOUNCE_CYCLES+1).
  - synced == level: dcnt <= 0.
  - synced != level and dcnt < DEBOUNCE_CYCLES-1: dcnt <= dcnt+1.
  - synced != level and dcnt == DEBOUNCE_CYCLES-1: toggle state, level <= synced, dcnt <= 0. Assert rise (LOW->HIGH) or fall (HIGH->LOW) for exactly the cycle in which the new level first appears.
- Latency: a clean input step sampled at edge 0 changes level, with the pulse, at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Glitches: any synced glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and is fully rejected. Bounce is never reported as multiple edges.
- rise and fall are never asserted together on one channel. Channels are fully independent, and simultaneous events on different channels each pulse in their own bit.
- Long press: per-channel counter hcnt, width clog2(LONG_CYCLES+1), saturating.
  - Cleared while level=0.
  - Increments while level=1 until it reaches LONG_CYCLES.
  - long_press pulses for one cycle on the transition of hcnt to LONG_CYCLES, i.e. LONG_CYCLES cycles after the rise pulse.
  - hcnt then holds, so no repeat. A new pulse requires a fall followed by a fresh press.
  - LONG_CYCLES=0: long_press tied to 0 and hcnt logic removed.
- Reset mid-operation: all state is discarded. If the input is still held after rst_n returns high, it is re-debounced as a fresh press: rise fires at SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first cycle with rst_n=1. No fall is emitted by the reset itself.
- Outputs are registered with no combinational path from btn_in. Counter arithmetic is unsigned, with no wrap: dcnt is bounded by the compare and hcnt saturates.

Decomposition:
- Shared package (button_pkg):
  - function clog2_min1, returning at least 1;
  - default timing constants DEBOUNCE_10MS_100MHZ and LONG_1S_100MHZ.
- Sub-module button_channel holds one channel: sync chain, FSM, dcnt, hcnt, pulses. button_conditioner instantiates CHANNELS copies in a generate loop and applies the ACTIVE_LOW inversion.

Test Plan (bench parameters CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=0 unless stated):
- Reset: rst_n=0 for 5 cycles with btn_in=2'b11 -> level, rise, fall and long_press are 0 throughout.
- Clean press: btn_in[0] 0->1 sampled at edge 0 and held -> level[0]=1 and rise[0]=1 at edge 6; rise[0]=0 at edge 7. Channel 1 outputs stay 0.
- Glitch and bounce:
  - btn_in[0] high for 3 cycles, then low -> no level/rise change.
  - Pattern 1,0,1,1,0,1 then steady 1 -> exactly one rise[0], 6 cycles after the final 0->1.
- Long press and release:
  - Hold ch0 -> long_press[0] single pulse 10 cycles after rise[0], never repeated while held.
  - Release -> fall[0] 6 cycles later.
  - Second press -> long_press fires again.
- Simultaneous and reset-mid-count:
  - Both channels rise at the same edge -> rise=2'b11 for one cycle.
  - Assert rst_n=0 while dcnt=2 -> no pulse; input still held after release -> rise 6 cycles after rst_n=1.
- ACTIVE_LOW=1: btn_in idles 2'b11 after reset -> no edges. Driving bit0 low -> rise[0] at edge 6.
